// File: rtl/dual_port_ram_be_if.sv
// Per-port request/response bundle for dual_port_ram_be.
// The master drives the request fields and the slave (the RAM) returns read data and status.
interface dual_port_ram_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                    en;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    err;

    modport master (
        output en, we, be, addr, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  en, we, be, addr, wdata,
        output rdata, rvalid, err
    );
endinterface

// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte-enable writes, 1- or 2-cycle read latency,
// per-port range errors and port-A-wins write-write merging with a collision flag.
module dual_port_ram_be #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    dual_port_ram_be_if.slave port_a,
    dual_port_ram_be_if.slave port_b,
    output logic              wr_collision
);
    localparam int                  BE_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req      [2];
    logic                  wr_sel   [2];
    logic [BE_W-1:0]       be       [2];
    logic [ADDR_WIDTH-1:0] addr     [2];
    logic [DATA_WIDTH-1:0] wdata    [2];
    logic                  in_range [2];
    logic                  do_wr    [2];
    logic                  do_rd    [2];
    logic [DATA_WIDTH-1:0] rdata_o  [2];
    logic                  rvalid_o [2];
    logic                  err_o    [2];

    assign req[0]    = port_a.en;
    assign wr_sel[0] = port_a.we;
    assign be[0]     = port_a.be;
    assign addr[0]   = port_a.addr;
    assign wdata[0]  = port_a.wdata;
    assign req[1]    = port_b.en;
    assign wr_sel[1] = port_b.we;
    assign be[1]     = port_b.be;
    assign addr[1]   = port_b.addr;
    assign wdata[1]  = port_b.wdata;

    assign port_a.rdata  = rdata_o[0];
    assign port_a.rvalid = rvalid_o[0];
    assign port_a.err    = err_o[0];
    assign port_b.rdata  = rdata_o[1];
    assign port_b.rvalid = rvalid_o[1];
    assign port_b.err    = err_o[1];

    // Port B is written first so that port A's byte lanes override it on a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BE_W; i++) begin
                if (do_wr[1] && be[1][i])
                    mem[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
                if (do_wr[0] && be[0][i])
                    mem[addr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= do_wr[0] && do_wr[1] && (addr[0] == addr[1]) && (|(be[0] & be[1]));
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  s1_valid;
        logic                  s1_err;
        logic [DATA_WIDTH-1:0] s1_data;

        assign in_range[p] = {1'b0, addr[p]} < DEPTH_X;
        assign do_wr[p]    = req[p] && wr_sel[p] && in_range[p];
        assign do_rd[p]    = req[p] && !wr_sel[p];

        // The array read sees pre-edge contents, which gives read-first behaviour across ports.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_err   <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= do_rd[p];
                s1_err   <= req[p] && !in_range[p];
                if (do_rd[p])
                    s1_data <= in_range[p] ? mem[addr[p]] : '0;
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic                  s2_err;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid)
                        s2_data <= s1_data;
                end
            end

            assign rdata_o[p]  = s2_data;
            assign rvalid_o[p] = s2_valid;
            assign err_o[p]    = s2_err;
        end else begin : g_lat1
            assign rdata_o[p]  = s1_data;
            assign rvalid_o[p] = s1_valid;
            assign err_o[p]    = s1_err;
        end
    end
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: one L=1/DEPTH=16 and one L=2/DEPTH=12 instance share stimulus;
// a per-cycle scoreboard checks rvalid/err/rdata and the collision flag on both.
module tb_dual_port_ram_be;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [1:0]       en;
        logic [1:0]       we;
        logic [1:0][1:0]  be;
        logic [1:0][3:0]  addr;
        logic [1:0][15:0] wd;
        logic [1:0][15:0] ex;
        logic             ec;
    } vec_t;

    typedef struct {
        int          due;
        logic        rvalid;
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic [1:0]       en;
    logic [1:0]       we;
    logic [1:0][1:0]  be;
    logic [1:0][3:0]  addr;
    logic [1:0][15:0] wd;

    logic [1:0][1:0] rv;
    logic [1:0][1:0] er;
    logic [15:0]     rd [2][2];
    logic [1:0]      coll;

    exp_t        q      [2][2][$];
    int          coll_q [2][$];
    logic [15:0] last   [2][2];
    int          total  = 0;
    int          passed = 0;

    dual_port_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if_a1 (), if_b1 (), if_a2 (), if_b2 ();

    assign if_a1.en = en[0];   assign if_a2.en = en[0];
    assign if_a1.we = we[0];   assign if_a2.we = we[0];
    assign if_a1.be = be[0];   assign if_a2.be = be[0];
    assign if_a1.addr = addr[0]; assign if_a2.addr = addr[0];
    assign if_a1.wdata = wd[0];  assign if_a2.wdata = wd[0];
    assign if_b1.en = en[1];   assign if_b2.en = en[1];
    assign if_b1.we = we[1];   assign if_b2.we = we[1];
    assign if_b1.be = be[1];   assign if_b2.be = be[1];
    assign if_b1.addr = addr[1]; assign if_b2.addr = addr[1];
    assign if_b1.wdata = wd[1];  assign if_b2.wdata = wd[1];

    dual_port_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .port_a(if_a1), .port_b(if_b1), .wr_collision(coll[0])
    );
    dual_port_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .port_a(if_a2), .port_b(if_b2), .wr_collision(coll[1])
    );

    always_comb begin
        rv[0][0] = if_a1.rvalid; er[0][0] = if_a1.err; rd[0][0] = if_a1.rdata;
        rv[0][1] = if_b1.rvalid; er[0][1] = if_b1.err; rd[0][1] = if_b1.rdata;
        rv[1][0] = if_a2.rvalid; er[1][0] = if_a2.err; rd[1][0] = if_a2.rdata;
        rv[1][1] = if_b2.rvalid; er[1][1] = if_b2.err; rd[1][1] = if_b2.rdata;
    end

    function automatic vec_t mk(logic ae, logic awe, logic [1:0] abe, logic [3:0] aa, logic [15:0] ad,
                                logic bn, logic bwe, logic [1:0] bbe, logic [3:0] ba, logic [15:0] bd,
                                logic [15:0] ea, logic [15:0] eb, logic ec);
        vec_t v;
        v.en = {bn, ae};  v.we = {bwe, awe};
        v.be[0] = abe;    v.be[1] = bbe;
        v.addr[0] = aa;   v.addr[1] = ba;
        v.wd[0] = ad;     v.wd[1] = bd;
        v.ex[0] = ea;     v.ex[1] = eb;
        v.ec = ec;
        return v;
    endfunction

    function automatic vec_t wa(logic [3:0] a, logic [15:0] d, logic [1:0] b);
        return mk(1, 1, b, a, d, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t wb(logic [3:0] a, logic [15:0] d, logic [1:0] b);
        return mk(0, 0, 0, 0, 0, 1, 1, b, a, d, 0, 0, 0);
    endfunction
    function automatic vec_t ra(logic [3:0] a, logic [15:0] e);
        return mk(1, 0, 0, a, 0, 0, 0, 0, 0, 0, e, 0, 0);
    endfunction
    function automatic vec_t rb(logic [3:0] a, logic [15:0] e);
        return mk(0, 0, 0, 0, 0, 1, 0, 0, a, 0, 0, e, 0);
    endfunction

    task automatic check_cycle();
        exp_t        e;
        logic [15:0] want;
        logic        want_c;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                e = '{due: edge_n, rvalid: 1'b0, err: 1'b0, data: 16'h0};
                if (q[i][p].size() > 0 && q[i][p][0].due == edge_n) e = q[i][p].pop_front();
                if (e.rvalid) last[i][p] = e.data;
                want = last[i][p];
                total++;
                if (rv[i][p] !== e.rvalid || er[i][p] !== e.err || rd[i][p] !== want)
                    $display("FAIL port%s_L%0d edge %0d: rvalid/err/rdata got %b/%b/%h want %b/%b/%h",
                             (p == 0) ? "A" : "B", i + 1, edge_n, rv[i][p], er[i][p], rd[i][p],
                             e.rvalid, e.err, want);
                else
                    passed++;
            end
            want_c = 1'b0;
            if (coll_q[i].size() > 0 && coll_q[i][0] == edge_n) begin
                void'(coll_q[i].pop_front());
                want_c = 1'b1;
            end
            total++;
            if (coll[i] !== want_c)
                $display("FAIL wr_collision_L%0d edge %0d: got %b want %b", i + 1, edge_n, coll[i], want_c);
            else
                passed++;
        end
    endtask

    task automatic drive(vec_t v);
        int   lat;
        int   dep;
        logic oor;
        en = v.en; we = v.we; be = v.be; addr = v.addr; wd = v.wd;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 2;
            dep = (i == 0) ? 16 : 12;
            for (int p = 0; p < 2; p++) begin
                if (v.en[p]) begin
                    oor = (int'(v.addr[p]) >= dep);
                    if (!v.we[p])
                        q[i][p].push_back('{due: edge_n + lat, rvalid: 1'b1, err: oor,
                                            data: oor ? 16'h0 : v.ex[p]});
                    else if (oor)
                        q[i][p].push_back('{due: edge_n + lat, rvalid: 1'b0, err: 1'b1, data: 16'h0});
                end
            end
            if (v.ec) coll_q[i].push_back(edge_n + 1);
        end
    endtask

    task automatic step(vec_t v);
        @(negedge clk);
        check_cycle();
        drive(v);
    endtask

    task automatic flush();
        for (int i = 0; i < 2; i++) begin
            coll_q[i].delete();
            for (int p = 0; p < 2; p++) begin
                q[i][p].delete();
                last[i][p] = 16'h0;
            end
        end
    endtask

    vec_t tbl [$];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        en = '0; we = '0; be = '0; addr = '0; wd = '0;
        flush();

        tbl.push_back(wa(3, 16'hBEEF, 2'b11));
        tbl.push_back(ra(3, 16'hBEEF));
        tbl.push_back(wa(5, 16'h1234, 2'b11));
        tbl.push_back(wa(5, 16'hAB00, 2'b10));
        tbl.push_back(rb(5, 16'hAB34));
        tbl.push_back(wa(7, 16'h0000, 2'b11));
        tbl.push_back(mk(1, 1, 2'b01, 7, 16'h1111, 1, 1, 2'b11, 7, 16'h2222, 0, 0, 1));
        tbl.push_back(ra(7, 16'h2211));
        tbl.push_back(wa(7, 16'h0000, 2'b11));
        tbl.push_back(mk(1, 1, 2'b10, 7, 16'h1111, 1, 1, 2'b01, 7, 16'h2222, 0, 0, 0));
        tbl.push_back(rb(7, 16'h1122));
        tbl.push_back(wa(2, 16'h00AA, 2'b11));
        tbl.push_back(mk(1, 1, 2'b11, 2, 16'h0055, 1, 0, 2'b00, 2, 16'h0, 0, 16'h00AA, 0));
        tbl.push_back(rb(2, 16'h0055));
        tbl.push_back(mk(1, 1, 2'b11, 0, 16'hC0DE, 1, 1, 2'b11, 1, 16'hF00D, 0, 0, 0));
        tbl.push_back(ra(0, 16'hC0DE));
        tbl.push_back(ra(1, 16'hF00D));
        tbl.push_back(ra(2, 16'h0055));
        tbl.push_back(ra(3, 16'hBEEF));
        tbl.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0, 5, 0, 16'hBEEF, 16'hAB34, 0));
        tbl.push_back(wa(13, 16'hDEAD, 2'b11));
        tbl.push_back(ra(13, 16'hDEAD));
        tbl.push_back(rb(13, 16'hDEAD));
        tbl.push_back(wa(4, 16'h5555, 2'b11));
        tbl.push_back(wb(4, 16'hFFFF, 2'b00));
        tbl.push_back(ra(4, 16'h5555));
        tbl.push_back(mk(0, 1, 2'b11, 3, 16'h0000, 0, 1, 2'b11, 3, 16'h0000, 0, 0, 0));
        tbl.push_back(ra(3, 16'hBEEF));
        tbl.push_back(wb(15, 16'h1234, 2'b11));
        tbl.push_back(rb(15, 16'h1234));

        repeat (2) step(idle);
        rst = 1'b0;

        foreach (tbl[k]) step(tbl[k]);
        repeat (3) step(idle);

        // Reset with reads still in the two-stage pipeline: none of them may surface.
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'hC0DE, 16'hF00D, 0));
        step(mk(1, 0, 0, 2, 0, 1, 0, 0, 3, 0, 16'h0055, 16'hBEEF, 0));
        @(negedge clk);
        check_cycle();
        drive(idle);
        rst = 1'b1;
        #1;
        flush();
        check_cycle();
        repeat (2) step(idle);
        rst = 1'b0;
        repeat (2) step(idle);
        step(mk(1, 0, 0, 3, 0, 1, 0, 0, 5, 0, 16'hBEEF, 16'hAB34, 0));
        repeat (4) step(idle);

        total++;
        if (q[0][0].size() + q[0][1].size() + q[1][0].size() + q[1][1].size()
            + coll_q[0].size() + coll_q[1].size() != 0)
            $display("FAIL drain: %0d expected events never seen, want 0",
                     q[0][0].size() + q[0][1].size() + q[1][0].size() + q[1][1].size()
                     + coll_q[0].size() + coll_q[1].size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
